// File: rtl/vga_draw_pkg.sv
`default_nettype none
// ============================================================================
// Module  : vga_draw_pkg
// Brief   : Shared types and constants for the VGA square/clear draw control.
// Revision: 1.0 - initial release
// ============================================================================
package vga_draw_pkg;

  // Controller states; CLEAR is only reachable when the clear feature is built in
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DRAW_SQ = 2'd1,
    S_CLEAR   = 2'd2
  } state_t;

  localparam int          SCR_W_DEF    = 160;
  localparam int          SCR_H_DEF    = 120;
  localparam int          COLOUR_W     = 3;
  localparam logic [2:0]  COLOUR_BLACK = 3'b000;

  // Base coordinate plus square offset, widened to 8 bits so overflow past
  // the 7-bit position range is visible to the caller
  function automatic logic [7:0] sq_coord(input logic [6:0] base, input logic [3:0] off);
    return {1'b0, base} + {4'b0000, off};
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_draw_ctrl_edge_det.sv
`default_nettype none
// ============================================================================
// Module  : vga_edge_det
// Brief   : Rising-edge detector for a level input. A level held high across
//           reset release is not reported until it is released and pressed
//           again.
// Revision: 1.0 - initial release
// ============================================================================
module vga_edge_det (
  input  logic clock,
  input  logic resetn,
  input  logic sig_i,
  output logic rise_o
);

  logic prev_q;
  logic armed_q;

  // Track previous level; arm only once the input has been seen low
  always_ff @(posedge clock) begin
    if (!resetn) begin
      prev_q  <= 1'b0;
      armed_q <= ~sig_i;
    end else begin
      prev_q  <= sig_i;
      armed_q <= armed_q | ~sig_i;
    end
  end

  assign rise_o = sig_i & ~prev_q & armed_q;

endmodule
`default_nettype wire

// File: rtl/vga_draw_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : vga_draw_ctrl
// Brief   : Draws SQ_SIZE x SQ_SIZE squares (clipped below the screen) and,
//           when VGA_DRAW_CLEAR_EN is defined, clears the whole screen to
//           black. Emits one pixel per cycle to a frame buffer.
// Revision: 1.0 - initial release
// ============================================================================
module vga_draw_ctrl
  import vga_draw_pkg::*;
#(
  parameter int SQ_SIZE = 4,
  parameter int SCR_W   = SCR_W_DEF,
  parameter int SCR_H   = SCR_H_DEF
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic [6:0]          pos_in,
  input  logic                store_pos,
  input  logic                clear_scr,
  input  logic                plot,
  input  logic [COLOUR_W-1:0] colour_in,
  output logic [7:0]          x,
  output logic [6:0]          y,
  output logic [COLOUR_W-1:0] colour,
  output logic                writeEn,
  output logic                busy
);

  localparam logic [3:0] SQ_LAST = 4'(SQ_SIZE - 1);
  localparam logic [7:0] Y_MAX   = 8'(SCR_H - 1);

  logic store_evt;
  logic plot_evt;
  logic clear_evt;

  state_t              state_q, state_d;
  logic [6:0]          xpos_q, xpos_d;
  logic [6:0]          ypos_q, ypos_d;
  logic                sel_y_q, sel_y_d;
  logic [COLOUR_W-1:0] col_q, col_d;
  logic [3:0]          cx_q, cx_d;
  logic [3:0]          cy_q, cy_d;
  logic [7:0]          x_q, x_d;
  logic [6:0]          y_q, y_d;
  logic [COLOUR_W-1:0] colour_q, colour_d;
  logic                we_q, we_d;
  logic [7:0]          sum_y;

  vga_edge_det u_store_edge (.clock(clock), .resetn(resetn), .sig_i(store_pos), .rise_o(store_evt));
  vga_edge_det u_plot_edge  (.clock(clock), .resetn(resetn), .sig_i(plot),      .rise_o(plot_evt));

`ifdef VGA_DRAW_CLEAR_EN
  localparam logic [7:0] X_LAST = 8'(SCR_W - 1);
  localparam logic [6:0] Y_LAST = 7'(SCR_H - 1);
  vga_edge_det u_clear_edge (.clock(clock), .resetn(resetn), .sig_i(clear_scr), .rise_o(clear_evt));
`else
  logic unused_clear;
  assign clear_evt    = 1'b0;
  assign unused_clear = clear_scr;
`endif

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      xpos_q   <= '0;
      ypos_q   <= '0;
      sel_y_q  <= 1'b0;
      col_q    <= COLOUR_BLACK;
      cx_q     <= '0;
      cy_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= COLOUR_BLACK;
      we_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      xpos_q   <= xpos_d;
      ypos_q   <= ypos_d;
      sel_y_q  <= sel_y_d;
      col_q    <= col_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      we_q     <= we_d;
    end
  end

  // Next state and the pixel to present next cycle
  always_comb begin
    state_d  = state_q;
    xpos_d   = xpos_q;
    ypos_d   = ypos_q;
    sel_y_d  = sel_y_q;
    col_d    = col_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    we_d     = 1'b0;
    sum_y    = '0;
    case (state_q)
      S_IDLE: begin
        if (clear_evt) begin
          state_d  = S_CLEAR;
          x_d      = '0;
          y_d      = '0;
          colour_d = COLOUR_BLACK;
          we_d     = 1'b1;
        end else if (plot_evt) begin
          state_d  = S_DRAW_SQ;
          col_d    = colour_in;
          cx_d     = '0;
          cy_d     = '0;
          sum_y    = sq_coord(ypos_q, 4'd0);
          x_d      = sq_coord(xpos_q, 4'd0);
          y_d      = sum_y[6:0];
          colour_d = colour_in;
          we_d     = (sum_y <= Y_MAX);
        end else if (store_evt) begin
          if (sel_y_q) ypos_d = pos_in;
          else         xpos_d = pos_in;
          sel_y_d = ~sel_y_q;
        end
      end
      S_DRAW_SQ: begin
        if (cx_q == SQ_LAST && cy_q == SQ_LAST) begin
          state_d = S_IDLE;
        end else begin
          if (cx_q == SQ_LAST) begin
            cx_d = '0;
            cy_d = cy_q + 4'd1;
          end else begin
            cx_d = cx_q + 4'd1;
          end
          // Rows below the screen still take a cycle but are not written
          sum_y    = sq_coord(ypos_q, cy_d);
          x_d      = sq_coord(xpos_q, cx_d);
          y_d      = sum_y[6:0];
          colour_d = col_q;
          we_d     = (sum_y <= Y_MAX);
        end
      end
`ifdef VGA_DRAW_CLEAR_EN
      S_CLEAR: begin
        // The output x/y registers double as the clear raster counter
        if (x_q == X_LAST && y_q == Y_LAST) begin
          state_d = S_IDLE;
        end else begin
          if (x_q == X_LAST) begin
            x_d = '0;
            y_d = y_q + 7'd1;
          end else begin
            x_d = x_q + 8'd1;
          end
          colour_d = COLOUR_BLACK;
          we_d     = 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign x       = x_q;
  assign y       = y_q;
  assign colour  = colour_q;
  assign writeEn = we_q;
  assign busy    = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_vga_draw_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_vga_draw_ctrl
// Brief   : Directed self-checking bench for vga_draw_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
module tb_vga_draw_ctrl;

  logic       clock = 1'b0;
  logic       resetn;
  logic [6:0] pos_in;
  logic       store_pos, clear_scr, plot;
  logic [2:0] colour_in;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       writeEn, busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  vga_draw_ctrl dut (
    .clock(clock), .resetn(resetn), .pos_in(pos_in), .store_pos(store_pos),
    .clear_scr(clear_scr), .plot(plot), .colour_in(colour_in),
    .x(x), .y(y), .colour(colour), .writeEn(writeEn), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One store_pos press followed by a low cycle
  task automatic press_store(input logic [6:0] p);
    pos_in = p;
    store_pos = 1'b1;
    tick();
    store_pos = 1'b0;
    tick();
  endtask

  // Plot press; on return the first pixel is on the outputs
  task automatic press_plot(input logic [2:0] c);
    colour_in = c;
    plot = 1'b1;
    tick();
    plot = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    check("wait_idle_timeout", 32'(n >= 100), 32'd0);
  endtask

  initial begin
    int we_cnt;
    int yf;
    resetn = 1'b0; pos_in = '0; store_pos = 1'b0; clear_scr = 1'b0;
    plot = 1'b0; colour_in = '0;
    tick(); tick();
    check("rst_x", 32'(x), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    check("rst_colour", 32'(colour), 32'd0);
    check("rst_we", 32'(writeEn), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // plot held high across reset release must not start a square
    plot = 1'b1;
    tick();
    resetn = 1'b1;
    tick(); tick(); tick();
    check("held_plot_busy", 32'(busy), 32'd0);
    check("held_plot_we", 32'(writeEn), 32'd0);
    plot = 1'b0;
    tick();
    press_plot(3'b001);
    check("repress_busy", 32'(busy), 32'd1);
    check("repress_pix", {writeEn, colour, x, 1'b0, y}, {1'b1, 3'b001, 8'd0, 8'd0});
    wait_idle();
    tick();

    // Basic square at (10,20); colour change mid-square must not show
    press_store(7'd10);
    press_store(7'd20);
    press_plot(3'b100);
    colour_in = 3'b011;
    for (int n = 0; n < 16; n++) begin
      check("sq_pix", {busy, writeEn, colour, x, 1'b0, y},
            {1'b1, 1'b1, 3'b100, 8'(10 + n % 4), 8'(20 + n / 4)});
      tick();
    end
    check("sq_end", {busy, writeEn, colour, x, 1'b0, y},
          {1'b0, 1'b0, 3'b100, 8'd13, 8'd23});

    // New event accepted in the first idle cycle; clipped square at bottom edge
    press_store(7'd127);
    press_store(7'd118);
    press_plot(3'b010);
    we_cnt = 0;
    for (int n = 0; n < 16; n++) begin
      yf = 118 + n / 4;
      check("clip_busy", 32'(busy), 32'd1);
      check("clip_x", 32'(x), 32'(127 + n % 4));
      check("clip_we", 32'(writeEn), 32'(yf <= 119));
      if (yf <= 119) check("clip_y", 32'(y), 32'(yf));
      if (writeEn) we_cnt++;
      tick();
    end
    check("clip_we_count", 32'(we_cnt), 32'd8);
    check("clip_end_busy", 32'(busy), 32'd0);

    // Reset mid-square; sel_y, X and Y must return to zero
    press_store(7'd40);
    press_store(7'd50);
    press_store(7'd7);
    press_plot(3'b001);
    check("abort_pix0", {x, 1'b0, y}, {8'd7, 8'd50});
    for (int n = 0; n < 5; n++) tick();
    check("abort_pix5", {writeEn, x, 1'b0, y}, {1'b1, 8'd8, 8'd51});
    resetn = 1'b0;
    tick();
    check("abort_we", {busy, writeEn, colour, x, 1'b0, y}, 21'd0);
    resetn = 1'b1;
    tick();
    press_store(7'd33);
    press_plot(3'b110);
    check("post_rst_pix", {busy, writeEn, colour, x, 1'b0, y},
          {1'b1, 1'b1, 3'b110, 8'd33, 8'd0});
    wait_idle();
    tick();

`ifdef VGA_DRAW_CLEAR_EN
    // Clear wins over a simultaneous plot; mid-clear plot is dropped
    press_store(7'd60);
    press_store(7'd60);
    clear_scr = 1'b1;
    plot = 1'b1;
    tick();
    clear_scr = 1'b0;
    plot = 1'b0;
    for (int n = 0; n < 19200; n++) begin
      check("clr_pix", {busy, writeEn, colour, x, 1'b0, y},
            {1'b1, 1'b1, 3'b000, 8'(n % 160), 1'b0, 7'(n / 160)});
      if (n == 100) plot = 1'b1;
      if (n == 102) plot = 1'b0;
      tick();
    end
    check("clr_end", {busy, writeEn, x, 1'b0, y}, {1'b0, 1'b0, 8'd159, 8'd119});
    for (int n = 0; n < 20; n++) begin
      check("clr_no_square", {busy, writeEn}, 2'b00);
      tick();
    end
`else
    // Clear disabled: clear_scr press does nothing
    clear_scr = 1'b1;
    tick();
    clear_scr = 1'b0;
    for (int n = 0; n < 10; n++) begin
      check("noclr_idle", {busy, writeEn}, 2'b00);
      tick();
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_draw_ctrl.md
VGA_DRAW_CTRL -- requirements
Module: vga_draw_ctrl

Interface
REQ-001 Parameter: SQ_SIZE, 4, square edge length in pixels (power of two, 1..8).
REQ-002 Parameter: SCR_W, 160, screen width in pixels.
REQ-003 Parameter: SCR_H, 120, screen height in pixels.
REQ-004 Port: clock  in  1  single system clock; all logic on its rising edge.
REQ-005 Port: resetn  in  1  reset, synchronous, active-low.
REQ-006 Port: pos_in  in  7  position value for X or Y.
REQ-007 Port: store_pos  in  1  active-high level; rising edge loads pos_in.
REQ-008 Port: clear_scr  in  1  active-high level; rising edge starts full-screen clear.
REQ-009 Port: plot  in  1  active-high level; rising edge starts square draw.
REQ-010 Port: colour_in  in  3  RGB colour for the square.
REQ-011 Port: x  out  8  pixel column to frame buffer.
REQ-012 Port: y  out  7  pixel row to frame buffer.
REQ-013 Port: colour  out  3  pixel colour to frame buffer.
REQ-014 Port: writeEn  out  1  pixel write strobe, one pixel per high cycle.
REQ-015 Port: busy  out  1  high while in DRAW_SQ or CLEAR.

Function
REQ-016 Rising edge on store_pos, plot, clear_scr = input high this cycle, low previous cycle; exactly one event per press.
REQ-017 store_pos events alternate: first loads X register, next loads Y register, then X again (select toggle sel_y).
REQ-018 FSM states: IDLE, DRAW_SQ, CLEAR; DRAW_SQ and CLEAR return to IDLE after last pixel.
REQ-019 In IDLE: clear_scr event -> CLEAR; else plot event -> DRAW_SQ; else store_pos event -> load register; simultaneous events resolved in that priority, losers dropped.
REQ-020 While busy, all three input events are ignored (not queued).
REQ-021 On plot event, colour_in is latched; later colour_in changes do not affect the square in progress.
REQ-022 Outputs are Moore: event at cycle k -> first pixel on x/y/writeEn at cycle k+1; pixel n at cycle k+1+n.
REQ-023 DRAW_SQ: SQ_SIZE*SQ_SIZE cycles, offsets cx fastest then cy; x = X+cx (8-bit), y = Y+cy.
REQ-024 DRAW_SQ clipping: Y+cy computed in 8 bits; if > SCR_H-1, writeEn low that cycle, cycle still consumed, y output don't-care.
REQ-025 CLEAR: SCR_W*SCR_H cycles (19200 default), x fastest 0..SCR_W-1, then y 0..SCR_H-1, colour 000, writeEn high every cycle.
REQ-026 busy drops and state is IDLE in the cycle after the last pixel; a new event is accepted in that cycle.
REQ-027 In IDLE: writeEn=0; x, y, colour hold last values.

Reset
REQ-028 resetn low at a clock edge: state IDLE, X=0, Y=0, sel_y=0, latched colour=0, x=0, y=0, colour=0, writeEn=0, busy=0, edge-detect history=0.
REQ-029 Reset mid-DRAW_SQ or mid-CLEAR aborts immediately; no further pixels written.
REQ-030 Input held high across reset release produces no event until released and pressed again.

Configuration
REQ-031 Macro VGA_DRAW_CLEAR_EN defined: CLEAR state and clear counter present per REQ-025.
REQ-032 Macro VGA_DRAW_CLEAR_EN undefined: clear_scr ignored, no CLEAR state, busy only in DRAW_SQ; all else unchanged.

Structure
REQ-033 Package vga_draw_pkg: state enum (IDLE, DRAW_SQ, CLEAR), default SCR_W/SCR_H constants, colour width constant (3), black colour constant.
REQ-034 One sub-module vga_edge_det (registered rising-edge detector, synchronous active-low reset), instantiated for store_pos, plot, clear_scr.

Verification
REQ-035 Press store_pos with pos_in=10, then 20; plot with colour_in=3'b100 -> 16 writeEn cycles, (x,y)=(10,20),(11,20)..(13,23), colour=100, busy 16 cycles.
REQ-036 X=127, Y=118, plot -> x 127..130; writeEn high only for rows 118,119 (8 pixels), 16 cycles total.
REQ-037 clear_scr -> 19200 writeEn cycles, colour 000, first (0,0), last (159,119); plot pressed mid-clear ignored.
REQ-038 clear_scr and plot rising in same cycle -> CLEAR only; no square afterwards.
REQ-039 resetn low at pixel 5 of a square -> writeEn 0 next cycle; next store_pos loads X (sel_y=0).
REQ-040 Build without VGA_DRAW_CLEAR_EN, press clear_scr -> writeEn stays 0, busy stays 0.
